// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the integer register scoreboard.
package reg_scoreboard_pkg;

    localparam int unsigned TAG_W_DEF = 3;
    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned COUNT_W   = 6;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard_decoder_5_32.sv
// One-hot 5-to-32 decoder with an enable; all-zero output when disabled.
module decoder_5_32
    import reg_scoreboard_pkg::*;
(
    input  logic                 i_en,
    input  logic [REG_IDX_W-1:0] i_idx,
    output logic [NREG-1:0]      o_onehot_c
);

    always_comb begin
        o_onehot_c = '0;
        if (i_en) begin
            o_onehot_c[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Busy/tag scoreboard for the 32 integer registers: set on issue, clear on
// tag-matching writeback, with same-cycle writeback bypass on source hazards.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic                 issue_rd_en,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [TAG_W-1:0]     issue_tag,
    input  logic                 rs1_en,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic                 rs2_en,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    output logic                 issue_ready,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [TAG_W-1:0]     wb_tag,
    input  logic                 flush,
    output logic [NREG-1:0]      busy_vec,
    output logic [COUNT_W-1:0]   busy_count
);

    logic [NREG-1:0]    r_busy;
    logic [TAG_W-1:0]   r_tag [NREG];
    logic [COUNT_W-1:0] r_count;

    logic               w_rs1_wb_hit;
    logic               w_rs2_wb_hit;
    logic               w_fire;
    logic               w_set_en;
    logic               w_clr_en;
    logic [NREG-1:0]    w_set_dec;
    logic [NREG-1:0]    w_clr;
    logic [NREG-1:0]    w_set;
    logic [NREG-1:0]    w_busy_nxt;
    logic [COUNT_W-1:0] w_count_nxt;

    // A writeback carrying the owning tag is forwarded by the register file,
    // so it already satisfies a reader this cycle.
    assign w_rs1_wb_hit = wb_valid && (wb_rd == rs1_addr) && (wb_tag == r_tag[rs1_addr]);
    assign w_rs2_wb_hit = wb_valid && (wb_rd == rs2_addr) && (wb_tag == r_tag[rs2_addr]);

    assign rs1_busy = rs1_en && (rs1_addr != REG_ZERO) && r_busy[rs1_addr] && !w_rs1_wb_hit;
    assign rs2_busy = rs2_en && (rs2_addr != REG_ZERO) && r_busy[rs2_addr] && !w_rs2_wb_hit;

    assign issue_ready = !flush && !rs1_busy && !rs2_busy;
    assign w_fire      = issue_valid && issue_ready;
    assign w_set_en    = w_fire && issue_rd_en && (issue_rd != REG_ZERO);
    // Stale writebacks (tag superseded by a younger issue) never clear.
    assign w_clr_en    = wb_valid && (wb_tag == r_tag[wb_rd]);

    decoder_5_32 u_set_dec (
        .i_en       (w_set_en),
        .i_idx      (issue_rd),
        .o_onehot_c (w_set_dec)
    );

    decoder_5_32 u_clr_dec (
        .i_en       (w_clr_en),
        .i_idx      (wb_rd),
        .o_onehot_c (w_clr)
    );

    assign w_set = w_set_dec & ~NREG'(1);

    // Next-state busy (flush > set > clr > hold) and its popcount.
    always_comb begin
        w_busy_nxt  = r_busy;
        w_count_nxt = '0;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            w_busy_nxt = (r_busy & ~w_clr) | w_set;
        end
        w_busy_nxt[0] = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_count_nxt = w_count_nxt + COUNT_W'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_set[i]) begin
                    r_tag[i] <= issue_tag;
                end
            end
        end
    end

    assign busy_vec   = r_busy;
    assign busy_count = r_count;

endmodule
